// File: rtl/multi_dice_roller.sv
// Purpose: N-die odometer dice roller with per-die hold; a roll FSM flags the settled throw.
// Latency: release sampled at edge k -> valid high for the cycle after edge k; throw is registered.
// Backpressure: none; enable=0 freezes every register, a pending valid is held until enable returns.
module multi_dice_roller #(
  parameter int N_DICE = 2,
  parameter int FACES  = 6
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      enable,
  input  logic                                      button,
  input  logic [N_DICE-1:0]                         hold,
  output logic [N_DICE*$clog2(FACES+1)-1:0]         throw,
  output logic [$clog2(N_DICE*FACES+1)-1:0]         sum,
  output logic                                      valid,
  output logic                                      all_match
);

  localparam int W  = $clog2(FACES + 1);
  localparam int SW = $clog2(N_DICE * FACES + 1);

  localparam logic [W-1:0] FACE_MAX = W'(FACES);
  localparam logic [W-1:0] FACE_ONE = W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic         do_step;
  logic         settle;
  logic         match;
  logic [W-1:0] die_q [N_DICE];
  logic [W-1:0] die_d [N_DICE];

  // Roll FSM: decides whether the dice step this edge and where the FSM goes next.
  always_comb begin
    state_d = state_q;
    do_step = 1'b0;
    settle  = 1'b0;
    case (state_q)
      IDLE: begin
        if (button) begin
          state_d = ROLL;
          do_step = 1'b1;
        end
      end
      ROLL: begin
        if (button) begin
          do_step = 1'b1;
        end else begin
          state_d = DONE;
          settle  = 1'b1;
        end
      end
      DONE: begin
        if (button) begin
          state_d = ROLL;
          do_step = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Odometer step: carry ripples from die 0 upward, held dice pass it through untouched.
  always_comb begin : step_calc
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < N_DICE; i++) begin
      die_d[i] = die_q[i];
      if (hold[i]) begin
        die_d[i] = die_q[i];
      end else if (die_q[i] == '0 || die_q[i] > FACE_MAX) begin
        // Corrupted value recovers to face 1 without disturbing the dice above.
        die_d[i] = FACE_ONE;
        carry    = 1'b0;
      end else if (carry) begin
        if (die_q[i] == FACE_MAX) begin
          die_d[i] = FACE_ONE;
          carry    = 1'b1;
        end else begin
          die_d[i] = die_q[i] + FACE_ONE;
          carry    = 1'b0;
        end
      end
    end
  end

  // All-equal detect on the current (registered) dice values.
  always_comb begin
    match = 1'b1;
    for (int i = 1; i < N_DICE; i++) begin
      if (die_q[i] != die_q[0]) match = 1'b0;
    end
  end

  // Sum of all dice and packing of the die registers onto the throw bus.
  always_comb begin
    sum   = '0;
    throw = '0;
    for (int i = 0; i < N_DICE; i++) begin
      sum             = sum + SW'(die_q[i]);
      throw[i*W +: W] = die_q[i];
    end
  end

  // State, dice, valid and all_match registers; reset wins over enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      valid     <= 1'b0;
      all_match <= 1'b0;
      for (int i = 0; i < N_DICE; i++) die_q[i] <= FACE_ONE;
    end else if (enable) begin
      state_q <= state_d;
      valid   <= (state_d == DONE);
      if (settle) all_match <= match;
      if (do_step) begin
        for (int i = 0; i < N_DICE; i++) die_q[i] <= die_d[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_dice_roller.sv
// Directed bench for multi_dice_roller (N_DICE=2, FACES=6).
// Stimulus pushes the expected settled throw on each release; a negedge monitor
// pops and compares whenever valid is high.
module tb_multi_dice_roller;

  localparam int N  = 2;
  localparam int W  = 3;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enable = 1'b1;
  logic            button = 1'b0;
  logic [N-1:0]    hold = '0;
  logic [N*W-1:0]  throw;
  logic [SW-1:0]   sum;
  logic            valid;
  logic            all_match;

  int total = 0;
  int bad = 0;
  int n_valid = 0;

  typedef struct packed {
    logic [N*W-1:0] thr;
    logic [SW-1:0]  sm;
    logic           m;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic prev_v = 1'b0;
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  multi_dice_roller #(.N_DICE(2), .FACES(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .button    (button),
    .hold      (hold),
    .throw     (throw),
    .sum       (sum),
    .valid     (valid),
    .all_match (all_match)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
  endtask

  task automatic push(input logic [N*W-1:0] thr, input logic [SW-1:0] sm, input logic m);
    exp_t e;
    e.thr = thr;
    e.sm  = sm;
    e.m   = m;
    sb.push_back(e);
  endtask

  // Monitor: every valid cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_valid++;
      chk("valid_width", {31'b0, prev_v & prev_en}, 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got valid with throw=%0h, required no valid", throw);
      end else begin
        cur = sb.pop_front();
        chk("sb_throw", {26'b0, throw}, {26'b0, cur.thr});
        chk("sb_sum", {28'b0, sum}, {28'b0, cur.sm});
        chk("sb_all_match", {31'b0, all_match}, {31'b0, cur.m});
      end
    end
    prev_v  = valid;
    prev_en = enable;
  end

  initial begin
    // 1: reset state
    rst = 1'b0;
    tick(2);
    chk("rst_throw", {26'b0, throw}, 32'h09);
    chk("rst_sum", {28'b0, sum}, 32'd2);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_match", {31'b0, all_match}, 32'd0);
    rst = 1'b1;
    tick(1);

    // 2: one sampled step, then release
    button = 1'b1;
    tick(1);
    chk("t2_step", {26'b0, throw}, {26'b0, 6'b001_010});
    button = 1'b0;
    push(6'b001_010, 4'd3, 1'b0);
    tick(3);
    chk("t2_idle_valid", {31'b0, valid}, 32'd0);

    // 3: seven steps from reset, die0 wraps and carries into die1
    do_reset();
    button = 1'b1;
    tick(5);
    chk("t3_die0_six", {26'b0, throw}, {26'b0, 6'b001_110});
    tick(1);
    chk("t3_wrap", {26'b0, throw}, {26'b0, 6'b010_001});
    tick(1);
    button = 1'b0;
    push(6'b010_010, 4'd4, 1'b1);
    tick(3);

    // 4: hold die1 for six steps, then hold die0 for three
    do_reset();
    hold = 2'b10;
    button = 1'b1;
    tick(6);
    chk("t4_hold1", {26'b0, throw}, {26'b0, 6'b001_001});
    button = 1'b0;
    push(6'b001_001, 4'd2, 1'b1);
    tick(3);
    hold = 2'b01;
    button = 1'b1;
    tick(3);
    chk("t4_hold0", {26'b0, throw}, {26'b0, 6'b100_001});
    button = 1'b0;
    push(6'b100_001, 4'd5, 1'b0);
    tick(3);
    hold = 2'b00;

    // 5: enable low mid-roll freezes everything
    do_reset();
    button = 1'b1;
    tick(2);
    chk("t5_pre", {26'b0, throw}, {26'b0, 6'b001_011});
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t5_frozen_throw", {26'b0, throw}, {26'b0, 6'b001_011});
      chk("t5_frozen_valid", {31'b0, valid}, 32'd0);
    end
    enable = 1'b1;
    tick(1);
    chk("t5_resume", {26'b0, throw}, {26'b0, 6'b001_100});
    button = 1'b0;
    push(6'b001_100, 4'd5, 1'b0);
    tick(3);

    // 6a: reset mid-roll with button and enable high
    do_reset();
    button = 1'b1;
    tick(3);
    chk("t6_pre", {26'b0, throw}, {26'b0, 6'b001_100});
    rst = 1'b0;
    tick(1);
    chk("t6a_throw", {26'b0, throw}, 32'h09);
    chk("t6a_sum", {28'b0, sum}, 32'd2);
    chk("t6a_valid", {31'b0, valid}, 32'd0);
    chk("t6a_match", {31'b0, all_match}, 32'd0);
    rst = 1'b1;
    button = 1'b0;
    tick(2);

    // 6b: reset during DONE with a matching throw
    button = 1'b1;
    tick(7);
    button = 1'b0;
    push(6'b010_010, 4'd4, 1'b1);
    tick(1);
    chk("t6b_done_valid", {31'b0, valid}, 32'd1);
    rst = 1'b0;
    button = 1'b1;
    tick(1);
    chk("t6b_throw", {26'b0, throw}, 32'h09);
    chk("t6b_valid", {31'b0, valid}, 32'd0);
    chk("t6b_match", {31'b0, all_match}, 32'd0);
    rst = 1'b1;
    button = 1'b0;
    tick(3);
    chk("t6b_idle", {26'b0, throw}, 32'h09);

    tick(3);
    chk("sb_empty", sb.size(), 32'd0);
    chk("valid_count", n_valid, 32'd6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
